// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: opcodes, FSM encoding
// and the op-class decode used to route instructions.
package mem_access_stage_pkg;

    localparam int unsigned OpW = 4;

    typedef enum logic [OpW-1:0] {
        OpAdd   = 4'h0,
        OpSub   = 4'h1,
        OpNand  = 4'h2,
        OpXor   = 4'h3,
        OpInc   = 4'h4,
        OpSra   = 4'h5,
        OpSrl   = 4'h6,
        OpSll   = 4'h7,
        OpLw    = 4'h8,
        OpSw    = 4'h9,
        OpLhb   = 4'hA,
        OpLlb   = 4'hB,
        OpB     = 4'hC,
        OpCall  = 4'hD,
        OpRet   = 4'hE,
        OpUndef = 4'hF
    } opcode_e;

    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } state_e;

    typedef enum logic [1:0] {
        ClsAlu,
        ClsBranch,
        ClsMem,
        ClsIllegal
    } op_class_e;

    function automatic op_class_e decode_class(input logic [OpW-1:0] op);
        op_class_e cls;
        case (op)
            OpAdd, OpSub, OpNand, OpXor, OpInc,
            OpSra, OpSrl, OpSll, OpLhb, OpLlb: cls = ClsAlu;
            OpB:                               cls = ClsBranch;
            OpLw, OpSw, OpCall, OpRet:         cls = ClsMem;
            default:                           cls = ClsIllegal;
        endcase
        return cls;
    endfunction

    function automatic logic is_mem_write(input logic [OpW-1:0] op);
        return (op == OpSw) || (op == OpCall);
    endfunction

endpackage

// File: rtl/mem_access_stage_timer.sv
// Wait counter for outstanding data-memory requests; expire is asserted in the
// TIMEOUT-th request cycle that has seen no acknowledge.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    input  logic ack,
    output logic expire
);

    logic [7:0] count_q, count_d;
    logic       run_q, run_d;

    always_comb begin
        count_d = count_q;
        run_d   = run_q;
        if (start) begin
            count_d = '0;
            run_d   = 1'b1;
        end else if (clear || ack) begin
            count_d = '0;
            run_d   = 1'b0;
        end else if (run_q) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            run_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            run_q   <= run_d;
        end
    end

    assign expire = run_q && (count_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: completes ALU/branch ops in one cycle and runs
// one data-memory transaction at a time for LW/SW/CALL/RET, with a timeout.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned OP_W    = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instr_in,
    input  logic [DATA_W-1:0] result,
    input  logic [DATA_W-1:0] rt,
    input  logic [ADDR_W-1:0] pc,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_ack,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [DATA_W-1:0] wb_data,
    output logic              ret_valid,
    output logic [ADDR_W-1:0] ret_addr,
    output logic              err_timeout,
    output logic              err_illegal
);

    state_e state_q, state_d;

    logic [OP_W-1:0]   op_raw;
    logic [OpW-1:0]    op_in;
    op_class_e         cls_in;
    logic              accept;
    logic              ack_eff;
    logic              expire;
    logic              timer_start;
    logic              timer_clear;

    logic [OpW-1:0]    op_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] rt_q;
    logic [ADDR_W-1:0] pc_q;

    logic              in_ready_q, in_ready_d;
    logic              dm_req_q, dm_req_d;
    logic              dm_we_q, dm_we_d;
    logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
    logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_we_q, wb_we_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              ret_valid_q, ret_valid_d;
    logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_illegal_q, err_illegal_d;

    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_in[DATA_W-OP_W-1:0];

    assign op_raw = instr_in[DATA_W-1 -: OP_W];
    assign op_in  = OpW'(op_raw);
    assign cls_in = decode_class(op_in);
    assign accept = in_valid && in_ready_q;
    // Acknowledge only counts while a request is actually outstanding.
    assign ack_eff = dm_ack && dm_req_q;

    assign timer_start = accept && (cls_in == ClsMem);
    assign timer_clear = (state_q == StAccess) && expire;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (timer_start),
        .clear  (timer_clear),
        .ack    (ack_eff),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept && (cls_in == ClsMem)) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (ack_eff || expire) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready_d    = (state_d == StIdle);
        dm_req_d      = dm_req_q;
        dm_we_d       = dm_we_q;
        dm_addr_d     = dm_addr_q;
        dm_wdata_d    = dm_wdata_q;
        wb_valid_d    = 1'b0;
        wb_we_d       = 1'b0;
        wb_data_d     = wb_data_q;
        ret_valid_d   = 1'b0;
        ret_addr_d    = ret_addr_q;
        err_timeout_d = 1'b0;
        err_illegal_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (cls_in)
                        ClsAlu: begin
                            wb_valid_d = 1'b1;
                            wb_we_d    = 1'b1;
                            wb_data_d  = result;
                        end
                        ClsBranch: begin
                            wb_valid_d = 1'b1;
                            wb_data_d  = result;
                        end
                        ClsIllegal: begin
                            wb_valid_d    = 1'b1;
                            err_illegal_d = 1'b1;
                        end
                        ClsMem: begin
                            dm_req_d   = 1'b1;
                            dm_we_d    = is_mem_write(op_in);
                            dm_addr_d  = (op_in == OpCall) ? ADDR_W'(rt) : ADDR_W'(result);
                            dm_wdata_d = (op_in == OpCall) ? DATA_W'(pc) :
                                         (op_in == OpSw)   ? rt : '0;
                        end
                        default: ;
                    endcase
                end
            end
            StAccess: begin
                if (ack_eff) begin
                    dm_req_d   = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_we_d    = (op_q != OpSw);
                    wb_data_d  = (op_q == OpLw) ? dm_rdata : result_q;
                    if (op_q == OpRet) begin
                        ret_valid_d = 1'b1;
                        ret_addr_d  = ADDR_W'(dm_rdata);
                    end
                end else if (expire) begin
                    dm_req_d      = 1'b0;
                    wb_valid_d    = 1'b1;
                    err_timeout_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            result_q <= '0;
            rt_q     <= '0;
            pc_q     <= '0;
        end else if (accept) begin
            op_q     <= op_in;
            result_q <= result;
            rt_q     <= rt;
            pc_q     <= pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q    <= 1'b0;
            dm_req_q      <= 1'b0;
            dm_we_q       <= 1'b0;
            dm_addr_q     <= '0;
            dm_wdata_q    <= '0;
            wb_valid_q    <= 1'b0;
            wb_we_q       <= 1'b0;
            wb_data_q     <= '0;
            ret_valid_q   <= 1'b0;
            ret_addr_q    <= '0;
            err_timeout_q <= 1'b0;
            err_illegal_q <= 1'b0;
        end else begin
            in_ready_q    <= in_ready_d;
            dm_req_q      <= dm_req_d;
            dm_we_q       <= dm_we_d;
            dm_addr_q     <= dm_addr_d;
            dm_wdata_q    <= dm_wdata_d;
            wb_valid_q    <= wb_valid_d;
            wb_we_q       <= wb_we_d;
            wb_data_q     <= wb_data_d;
            ret_valid_q   <= ret_valid_d;
            ret_addr_q    <= ret_addr_d;
            err_timeout_q <= err_timeout_d;
            err_illegal_q <= err_illegal_d;
        end
    end

    // rt/pc are consumed at accept time; the latched copies are kept for debug visibility.
    logic unused_latched;
    assign unused_latched = ^{rt_q, pc_q};

    assign in_ready    = in_ready_q;
    assign dm_req      = dm_req_q;
    assign dm_we       = dm_we_q;
    assign dm_addr     = dm_addr_q;
    assign dm_wdata    = dm_wdata_q;
    assign wb_valid    = wb_valid_q;
    assign wb_we       = wb_we_q;
    assign wb_data     = wb_data_q;
    assign ret_valid   = ret_valid_q;
    assign ret_addr    = ret_addr_q;
    assign err_timeout = err_timeout_q;
    assign err_illegal = err_illegal_q;

endmodule
